// File: rtl/core_pkg.sv
// Shared definitions for the single-cycle RISC-V core:
// branch encodings, exception causes, PC FSM states and ALU select codes.
package core_pkg;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

    localparam logic [3:0] ALU_SEL_ADD = 4'b0010;
    localparam logic [3:0] ALU_SEL_SUB = 4'b0110;
    localparam logic [3:0] ALU_SEL_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_TRAP = 2'b01,
        ST_HALT = 2'b10
    } pc_state_e;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch condition: maps Funct3 and ALU flags to
// taken / illegal.
module branch_resolve
    import core_pkg::*;
(
    input  logic [2:0] Funct3,
    input  logic       Zero,
    input  logic       Alu_Lsb,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        unique case (Funct3)
            F3_BEQ:  taken = Zero;
            F3_BNE:  taken = ~Zero;
            F3_BLT:  taken = Alu_Lsb;
            F3_BGE:  taken = ~Alu_Lsb;
            // ALU has no unsigned compare, so BLTU/BGEU are rejected too
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter, next-PC select, trap/halt FSM and retired-instruction
// counter of the single-cycle core.
module pc_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [2:0]  Funct3,
    input  logic        Jump,
    input  logic        Jalr,
    input  logic [31:0] Imm,
    input  logic [31:0] ALU_Out,
    input  logic        Zero,
    output logic [31:0] PC,
    output logic [31:0] PC_Plus4,
    output logic [31:0] Epc,
    output logic [1:0]  Cause,
    output logic        Trap_Taken,
    output logic        Halted,
    output logic [63:0] Instret
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [63:0] instret_q, instret_d;

    logic        br_taken, br_illegal;
    logic        redirect, illegal, misalign, fault;
    logic [31:0] next_pc, target;
    logic [1:0]  fault_cause;

    branch_resolve u_branch_resolve (
        .Funct3  (Funct3),
        .Zero    (Zero),
        .Alu_Lsb (ALU_Out[0]),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    always_comb begin
        target   = pc_q + Imm;
        redirect = 1'b1;
        if (Jalr) begin
            target = ALU_Out & ~32'h1;
        end else if (Jump) begin
            target = pc_q + Imm;
        end else if (Branch && br_taken) begin
            target = pc_q + Imm;
        end else begin
            redirect = 1'b0;
        end
        next_pc     = redirect ? target : pc_q + 32'd4;
        illegal     = Branch && br_illegal;
        misalign    = redirect && (target[1:0] != 2'b00);
        fault       = illegal || misalign;
        fault_cause = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        if (!Stall) begin
            unique case (state_q)
                ST_RUN, ST_TRAP: begin
                    if (fault) begin
                        epc_d   = pc_q;
                        cause_d = fault_cause;
                        if (state_q == ST_RUN) begin
                            pc_d    = TRAP_VEC;
                            state_d = ST_TRAP;
                        end else begin
                            state_d = ST_HALT;
                        end
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 64'd1;
                        state_d   = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            epc_q     <= 32'h0;
            cause_q   <= CAUSE_NONE;
            instret_q <= 64'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign PC         = pc_q;
    assign PC_Plus4   = pc_q + 32'd4;
    assign Epc        = epc_q;
    assign Cause      = cause_q;
    assign Trap_Taken = (state_q == ST_TRAP);
    assign Halted     = (state_q == ST_HALT);
    assign Instret    = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed PC,
// trap and counter expectations.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, Stall, Branch, Jump, Jalr, Zero;
    logic [2:0]  Funct3;
    logic [31:0] Imm, ALU_Out;
    logic [31:0] PC, PC_Plus4, Epc;
    logic [1:0]  Cause;
    logic        Trap_Taken, Halted;
    logic [63:0] Instret;

    int vectors = 0;
    int errors  = 0;

    pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .Branch     (Branch),
        .Funct3     (Funct3),
        .Jump       (Jump),
        .Jalr       (Jalr),
        .Imm        (Imm),
        .ALU_Out    (ALU_Out),
        .Zero       (Zero),
        .PC         (PC),
        .PC_Plus4   (PC_Plus4),
        .Epc        (Epc),
        .Cause      (Cause),
        .Trap_Taken (Trap_Taken),
        .Halted     (Halted),
        .Instret    (Instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Stall = 0; Branch = 0; Jump = 0; Jalr = 0; Zero = 0;
        Funct3 = 3'b000; Imm = 32'h0; ALU_Out = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        chk("rst_pc", PC, 0);
        chk("rst_plus4", PC_Plus4, 4);
        chk("rst_epc", Epc, 0);
        chk("rst_cause", Cause, 0);
        chk("rst_trap", Trap_Taken, 0);
        chk("rst_halt", Halted, 0);
        chk("rst_instret", Instret, 0);

        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc", PC, 64'(4 * i));
        end
        chk("seq_instret", Instret, 4);
        for (int i = 0; i < 4; i++) step();
        chk("seq_pc20", PC, 32'h20);

        Branch = 1; Funct3 = 3'b000; Imm = 32'h40; Zero = 1;
        step();
        chk("beq_taken", PC, 32'h60);
        Imm = 32'hFFFF_FFC0;
        step();
        chk("beq_back", PC, 32'h20);
        Imm = 32'h40; Zero = 0;
        step();
        chk("beq_not", PC, 32'h24);
        idle(); Jump = 1; Imm = 32'hFFFF_FFFC;
        step();
        chk("jal_back", PC, 32'h20);

        idle(); Branch = 1; Funct3 = 3'b100; Imm = 32'h40; ALU_Out = 1;
        step();
        chk("blt_taken", PC, 32'h60);
        idle(); Jump = 1; Imm = 32'hFFFF_FFC0;
        step();
        chk("jal_back2", PC, 32'h20);
        idle(); Branch = 1; Funct3 = 3'b100; Imm = 32'h40; ALU_Out = 0;
        step();
        chk("blt_not", PC, 32'h24);

        idle(); Jalr = 1; ALU_Out = 32'h1235;
        step();
        chk("jalr_pc", PC, 32'h1234);
        chk("jalr_plus4", PC_Plus4, 32'h1238);
        chk("instret16", Instret, 16);
        ALU_Out = 32'h10;
        step();
        chk("jalr_pc10", PC, 32'h10);

        idle(); Stall = 1; Jump = 1; Imm = 32'h6;
        step();
        chk("stall_pc", PC, 32'h10);
        chk("stall_trap", Trap_Taken, 0);
        chk("stall_epc", Epc, 0);
        chk("stall_cause", Cause, 0);
        chk("stall_instret", Instret, 17);

        Stall = 0;
        step();
        chk("mis_pc", PC, 32'h100);
        chk("mis_epc", Epc, 32'h10);
        chk("mis_cause", Cause, 2'b01);
        chk("mis_trap", Trap_Taken, 1);
        chk("mis_instret", Instret, 17);

        idle(); Stall = 1;
        step();
        chk("trap_stall_ext", Trap_Taken, 1);
        chk("trap_stall_pc", PC, 32'h100);

        idle();
        step();
        chk("trap_exit", Trap_Taken, 0);
        chk("trap_exit_pc", PC, 32'h104);
        chk("trap_exit_ir", Instret, 18);
        chk("trap_exit_halt", Halted, 0);

        Jump = 1; Imm = 32'h2;
        step();
        chk("mis2_pc", PC, 32'h100);
        chk("mis2_epc", Epc, 32'h104);
        idle(); Branch = 1; Funct3 = 3'b110;
        step();
        chk("dbl_halt", Halted, 1);
        chk("dbl_cause", Cause, 2'b10);
        chk("dbl_epc", Epc, 32'h100);
        chk("dbl_trap", Trap_Taken, 0);
        idle();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_pc", PC, 32'h100);
        end
        chk("halt_instret", Instret, 18);
        chk("halt_still", Halted, 1);

        reset = 1; Stall = 1; Jump = 1; Imm = 32'h2;
        step();
        reset = 0; idle();
        chk("rst2_pc", PC, 0);
        chk("rst2_halt", Halted, 0);
        chk("rst2_instret", Instret, 0);
        chk("rst2_cause", Cause, 0);

        Branch = 1; Funct3 = 3'b111; Jump = 1; Imm = 32'h2;
        step();
        chk("both_pc", PC, 32'h100);
        chk("both_cause", Cause, 2'b10);
        chk("both_trap", Trap_Taken, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
